button_event_ctrl: RTL and testbench
====================================

Name: button_event_ctrl

Overview:
Multi-button input controller that debounces NUM_BTN raw button lines with one shared sample-tick prescaler and per-button stable-count channels. It turns debounced transitions into PRESS, LONG and RELEASE events. A round-robin arbiter schedules the events onto a single valid/ready event port. It sits between the board pins and the UI/command logic and replaces per-button free-running debouncers.

Parameters:
NUM_BTN, 4, number of button inputs (>=1).
TICK_DIV, 1000, clocks per sample tick (>=2).
DEB_TICKS, 16, consecutive stable ticks needed to accept a level change (>=1).
LONG_TICKS, 1000, ticks held after PRESS before LONG fires (>=1).

Ports:
clk  in  1  system clock.
reset_n  in  1  asynchronous, active-low reset.
btn_in  in  NUM_BTN  raw asynchronous button levels, 1 = pressed.
btn_state  out  NUM_BTN  debounced levels.
evt_valid  out  1  event available.
evt_ready  in  1  consumer accepts event.
evt_id  out  IDW  button index; IDW = max(1, clog2(NUM_BTN)).
evt_type  out  2  0 = PRESS, 1 = RELEASE, 2 = LONG; 3 is never driven.
evt_overflow  out  1  one-cycle pulse: an event was lost.

Behaviour:
- One clock domain. Reset is asynchronous and active-low (reset_n). On reset, all of the following clear to 0: synchronizers, counters, pending bits, the RR pointer, btn_state, evt_valid, evt_id, evt_type and evt_overflow.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick = 1 for exactly one cycle when count == TICK_DIV-1.
- Per button: 2-flop synchronizer on btn_in, then a debounce counter evaluated only on tick.
  - sync == btn_state: counter clears to 0.
  - sync != btn_state: counter increments. On the tick where it would reach DEB_TICKS, btn_state flips, the counter clears, and the matching pending bit is set (PRESS on 0->1, RELEASE on 1->0).
  - The filter is symmetric for press and release.
- Hold counter: active while btn_state = 1 and increments on tick, saturating at LONG_TICKS.
  - On the tick it reaches LONG_TICKS, pending LONG is set once per press.
  - It clears when btn_state = 0.
- Pending: 3 bits per button (PRESS/LONG/RELEASE).
  - Setting a bit that is already set (and not being consumed this cycle) drops the event and pulses evt_overflow in the next cycle.
  - If a set and a consume of the same bit happen in the same cycle, the set wins and there is no overflow.
- Arbiter/output register: loads when evt_valid = 0 or (evt_valid & evt_ready).
  - Search starts at button (last_grant+1) mod NUM_BTN and picks the first button with any pending bit.
  - Within a button, priority is PRESS > LONG > RELEASE (chronological order).
  - On load: the chosen pending bit clears, evt_id/evt_type register, evt_valid = 1, and last_grant updates.
  - If nothing is pending, evt_valid goes to 0.
- Handshake: while evt_valid & !evt_ready, evt_id and evt_type are held stable. Back-to-back transfers are allowed: one event per cycle when ready is held high.
- Latency: pending bit set at the end of the tick cycle; evt_valid rises the following cycle if the output register is free.
- Reset mid-operation clears all state immediately; no events are emitted for buttons held through reset until they satisfy debounce again.

Optional Feature:
BTN_LONG_PRESS_EN
- Defined: hold counters and LONG pending bits exist; behaviour as above.
- Undefined: no hold counters and LONG_TICKS is ignored. evt_type 2 is never produced. Encodings are unchanged.

Decomposition:
- Package btn_event_pkg: evt_type localparams EVT_PRESS=2'd0, EVT_RELEASE=2'd1, EVT_LONG=2'd2, plus the IDW width rule.
- Sub-module btn_event_chan: synchronizer, debounce counter and hold counter for one button, with tick input and press/release/long set strobes out. Instantiated NUM_BTN times in a generate loop.
- The arbiter and output register stay in the top.

Test Plan:
Bench config for all scenarios: NUM_BTN=4, TICK_DIV=4, DEB_TICKS=3, LONG_TICKS=5, evt_ready=1 unless stated.
1. Reset with btn_in=4'hF held -> all outputs 0 during reset. After release of reset, btn_state=4'hF and four PRESS events appear only after sync plus 3 ticks.
2. Raise btn_in[0] and hold -> btn_state[0] rises within 2 + 3×4 + 4 clocks. evt_valid=1 with evt_id=0, evt_type=0 for exactly one cycle.
3. Toggle btn_in[1] every 6 clocks (fewer than 3 stable ticks) for 200 clocks -> btn_state[1]=0, no events, no overflow.
4. btn_in[2] and btn_in[3] rise in the same cycle, evt_ready=0 -> evt_valid held with id=2, type=0, stable for 20 clocks. Raise ready -> (2,PRESS) then (3,PRESS) on consecutive cycles.
5. Hold btn0 for 3+5 ticks then release -> PRESS, LONG, RELEASE in order. With BTN_LONG_PRESS_EN undefined -> PRESS, RELEASE only.
6. evt_ready=0, btn1 pressed, released, then pressed again -> second PRESS drops and evt_overflow pulses 1 cycle. Ready=1 -> (1,PRESS), (1,RELEASE) only.

Source files
------------

// File: rtl/btn_event_pkg.sv
// Shared event encodings and id-width rule for button_event_ctrl.
// Optional LONG events are built only when BTN_LONG_PRESS_EN is defined.
package btn_event_pkg;

  localparam logic [1:0] EVT_PRESS   = 2'd0;
  localparam logic [1:0] EVT_RELEASE = 2'd1;
  localparam logic [1:0] EVT_LONG    = 2'd2;

  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_event_ctrl_if.sv
// Event port of button_event_ctrl: valid/ready handshake plus
// the one-cycle overflow pulse.
interface button_event_ctrl_if #(
  parameter int IDW = 2
);

  logic           evt_valid;
  logic           evt_ready;
  logic [IDW-1:0] evt_id;
  logic [1:0]     evt_type;
  logic           evt_overflow;

  modport master (
    output evt_valid,
    output evt_id,
    output evt_type,
    output evt_overflow,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_id,
    input  evt_type,
    input  evt_overflow,
    output evt_ready
  );

endinterface

// File: rtl/btn_event_chan.sv
// One button: 2-flop sync, tick-based debounce, optional hold counter.
// Hold counter and LONG strobe exist only with BTN_LONG_PRESS_EN.
module btn_event_chan #(
  parameter int DEB_TICKS  = 16,
  parameter int LONG_TICKS = 1000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic btn_in,
  output logic state,
  output logic set_press,
  output logic set_release,
  output logic set_long
);

  localparam int DW = $clog2(DEB_TICKS + 1);
  localparam logic [DW-1:0] DLAST = DW'(DEB_TICKS - 1);

  logic [1:0]    sync;
  logic [DW-1:0] dcnt;
  logic          diff;
  logic          flip;

  assign diff = sync[1] ^ state;
  assign flip = tick & diff & (dcnt == DLAST);

  assign set_press   = flip & ~state;
  assign set_release = flip & state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync  <= '0;
      dcnt  <= '0;
      state <= 1'b0;
    end else begin
      sync <= {sync[0], btn_in};
      if (tick) begin
        if (!diff) begin
          dcnt <= '0;
        end else if (flip) begin
          dcnt  <= '0;
          state <= ~state;
        end else begin
          dcnt <= dcnt + DW'(1);
        end
      end
    end
  end

`ifdef BTN_LONG_PRESS_EN
  localparam int HW = $clog2(LONG_TICKS + 1);
  localparam logic [HW-1:0] HMAX  = HW'(LONG_TICKS);
  localparam logic [HW-1:0] HLAST = HW'(LONG_TICKS - 1);

  logic [HW-1:0] hcnt;

  // saturation keeps LONG to a single strobe per press
  assign set_long = tick & state & (hcnt == HLAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt <= '0;
    end else if (!state) begin
      hcnt <= '0;
    end else if (tick && hcnt != HMAX) begin
      hcnt <= hcnt + HW'(1);
    end
  end
`else
  localparam int unused_long_ticks = LONG_TICKS;

  assign set_long = 1'b0;
`endif

endmodule

// File: rtl/button_event_ctrl.sv
// Debounced multi-button PRESS/RELEASE(/LONG) event source, round-robin
// onto one valid/ready port. LONG events need BTN_LONG_PRESS_EN.
module button_event_ctrl
  import btn_event_pkg::*;
#(
  parameter int NUM_BTN    = 4,
  parameter int TICK_DIV   = 1000,
  parameter int DEB_TICKS  = 16,
  parameter int LONG_TICKS = 1000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] btn_state,
  button_event_ctrl_if.master evt
);

  localparam int IDW = id_w(NUM_BTN);
  localparam int PW  = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] pcnt;
  logic          tick;

  assign tick = (pcnt == PMAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt <= '0;
    end else begin
      pcnt <= tick ? '0 : pcnt + PW'(1);
    end
  end

  logic [NUM_BTN-1:0] set_p;
  logic [NUM_BTN-1:0] set_r;
  logic [NUM_BTN-1:0] set_l;

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_chan
    btn_event_chan #(
      .DEB_TICKS  (DEB_TICKS),
      .LONG_TICKS (LONG_TICKS)
    ) u_chan (
      .clk         (clk),
      .reset_n     (reset_n),
      .tick        (tick),
      .btn_in      (btn_in[gi]),
      .state       (btn_state[gi]),
      .set_press   (set_p[gi]),
      .set_release (set_r[gi]),
      .set_long    (set_l[gi])
    );
  end

  logic [NUM_BTN-1:0] pend_p;
  logic [NUM_BTN-1:0] pend_r;
  logic [NUM_BTN-1:0] pend_l;
  logic [NUM_BTN-1:0] pend_any;
  logic [NUM_BTN-1:0] clr_p;
  logic [NUM_BTN-1:0] clr_r;
  logic [NUM_BTN-1:0] clr_l;

  logic           v_q;
  logic [IDW-1:0] id_q;
  logic [1:0]     ty_q;
  logic           ovf_q;
  logic [IDW-1:0] last_q;

  logic           load;
  logic           found;
  logic [IDW-1:0] cand;
  logic [IDW-1:0] gnt;
  logic [1:0]     gtype;

  assign pend_any = pend_p | pend_l | pend_r;

  always_comb begin
    load  = !v_q || evt.evt_ready;
    found = 1'b0;
    cand  = '0;
    gnt   = '0;
    gtype = EVT_PRESS;
    clr_p = '0;
    clr_r = '0;
    clr_l = '0;
    for (int k = 0; k < NUM_BTN; k++) begin
      cand = IDW'((int'(last_q) + 1 + k) % NUM_BTN);
      if (!found && pend_any[cand]) begin
        found = 1'b1;
        gnt   = cand;
      end
    end
    // oldest event of the granted button goes first
    if (load && found) begin
      if (pend_p[gnt]) begin
        gtype      = EVT_PRESS;
        clr_p[gnt] = 1'b1;
      end else if (pend_l[gnt]) begin
        gtype      = EVT_LONG;
        clr_l[gnt] = 1'b1;
      end else begin
        gtype      = EVT_RELEASE;
        clr_r[gnt] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_p <= '0;
      pend_r <= '0;
      pend_l <= '0;
      ovf_q  <= 1'b0;
      v_q    <= 1'b0;
      id_q   <= '0;
      ty_q   <= EVT_PRESS;
      last_q <= '0;
    end else begin
      pend_p <= (pend_p & ~clr_p) | set_p;
      pend_r <= (pend_r & ~clr_r) | set_r;
      pend_l <= (pend_l & ~clr_l) | set_l;
      // a same-cycle consume frees the slot, so that set is not a loss
      ovf_q  <= |((pend_p & ~clr_p & set_p) |
                  (pend_r & ~clr_r & set_r) |
                  (pend_l & ~clr_l & set_l));
      if (load) begin
        v_q <= found;
        if (found) begin
          id_q   <= gnt;
          ty_q   <= gtype;
          last_q <= gnt;
        end
      end
    end
  end

  assign evt.evt_valid    = v_q;
  assign evt.evt_id       = id_q;
  assign evt.evt_type     = ty_q;
  assign evt.evt_overflow = ovf_q;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench for button_event_ctrl (NUM_BTN=4, TICK_DIV=4,
// DEB_TICKS=3, LONG_TICKS=5); LONG expectations follow BTN_LONG_PRESS_EN.
module tb_button_event_ctrl;
  import btn_event_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] btn_in = 4'h0;
  logic [3:0] btn_state;

  button_event_ctrl_if #(.IDW(2)) bus ();

  button_event_ctrl #(
    .NUM_BTN    (4),
    .TICK_DIV   (4),
    .DEB_TICKS  (3),
    .LONG_TICKS (5)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .btn_in    (btn_in),
    .btn_state (btn_state),
    .evt       (bus)
  );

  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;
  int cyc = 0;

  int ev_id[$];
  int ev_ty[$];
  int ev_cyc[$];
  int ovf_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.evt_valid && bus.evt_ready) begin
        ev_id.push_back(int'(bus.evt_id));
        ev_ty.push_back(int'(bus.evt_type));
        ev_cyc.push_back(cyc);
      end
      if (bus.evt_overflow) ovf_log.push_back(cyc);
    end
  end

  typedef struct {
    logic [3:0] btn;
    int         cycles;
    logic [3:0] exp_state;
  } vec_t;

  vec_t tbl[9];

  int exp_id[$];
  int exp_ty[$];

  task automatic chk(input string name, input int act, input int exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rst_on(input logic [3:0] b);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    btn_in = b;
    bus.evt_ready = 1'b1;
    step(1);
  endtask

  task automatic rst_off();
    ev_id.delete();
    ev_ty.delete();
    ev_cyc.delete();
    ovf_log.delete();
    reset_n = 1'b1;
  endtask

  task automatic wait_state(input logic [3:0] exp, input int budget,
                            input string name);
    int i = 0;
    while (btn_state !== exp && i < budget) begin
      step(1);
      i++;
    end
    chk(name, int'(btn_state), int'(exp));
  endtask

  task automatic chk_ev(input string name, input int k,
                        input int id, input int ty);
    if (k < ev_id.size()) begin
      chk({name, "_id"}, ev_id[k], id);
      chk({name, "_type"}, ev_ty[k], ty);
    end else begin
      chk({name, "_missing"}, ev_id.size(), k + 1);
    end
  endtask

  task automatic chk_list(input string name);
    chk({name, "_count"}, ev_id.size(), exp_id.size());
    for (int k = 0; k < exp_id.size(); k++)
      chk_ev(name, k, exp_id[k], exp_ty[k]);
  endtask

  task automatic add_exp(input int id, input logic [1:0] ty);
    exp_id.push_back(id);
    exp_ty.push_back(int'(ty));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad;
    bus.evt_ready = 1'b1;

    // reset with all buttons held
    rst_on(4'hF);
    chk("rst_btn_state", int'(btn_state), 0);
    chk("rst_evt_outs",
        int'({bus.evt_valid, bus.evt_id, bus.evt_type, bus.evt_overflow}),
        0);
    rst_off();
    step(8);
    chk("held_early_state", int'(btn_state), 0);
    chk("held_early_events", ev_id.size(), 0);
    wait_state(4'hF, 14, "held_state");
    step(6);
    exp_id.delete();
    exp_ty.delete();
    add_exp(1, EVT_PRESS);
    add_exp(2, EVT_PRESS);
    add_exp(3, EVT_PRESS);
    add_exp(0, EVT_PRESS);
    chk_list("held_press");

    // debounce table
    tbl[0] = '{4'h0, 20, 4'h0};
    tbl[1] = '{4'h1,  8, 4'h0};
    tbl[2] = '{4'h1, 12, 4'h1};
    tbl[3] = '{4'h0,  8, 4'h1};
    tbl[4] = '{4'h0, 12, 4'h0};
    tbl[5] = '{4'h6, 20, 4'h6};
    tbl[6] = '{4'h0, 20, 4'h0};
    tbl[7] = '{4'h8, 20, 4'h8};
    tbl[8] = '{4'h0, 20, 4'h0};
    rst_on(4'h0);
    rst_off();
    for (int i = 0; i < 9; i++) begin
      btn_in = tbl[i].btn;
      step(tbl[i].cycles);
      chk($sformatf("tbl%0d_state", i), int'(btn_state),
          int'(tbl[i].exp_state));
    end
    begin
      int n = 0;
      exp_id.delete();
      exp_ty.delete();
      add_exp(0, EVT_PRESS);
      add_exp(0, EVT_RELEASE);
      add_exp(1, EVT_PRESS);
      add_exp(2, EVT_PRESS);
      add_exp(1, EVT_RELEASE);
      add_exp(2, EVT_RELEASE);
      add_exp(3, EVT_PRESS);
      add_exp(3, EVT_RELEASE);
      for (int k = 0; k < ev_id.size(); k++) begin
        if (ev_ty[k] != int'(EVT_LONG)) begin
          if (n < exp_id.size()) begin
            chk($sformatf("tbl_ev%0d_id", n), ev_id[k], exp_id[n]);
            chk($sformatf("tbl_ev%0d_type", n), ev_ty[k], exp_ty[n]);
          end
          n++;
        end
      end
      chk("tbl_ev_count", n, exp_id.size());
    end
    chk("tbl_overflow", ovf_log.size(), 0);

    // bounce shorter than the filter
    rst_on(4'h0);
    rst_off();
    for (int i = 0; i < 34; i++) begin
      btn_in[1] = ~btn_in[1];
      step(6);
    end
    btn_in = 4'h0;
    chk("bounce_state", int'(btn_state), 0);
    chk("bounce_events", ev_id.size(), 0);
    chk("bounce_overflow", ovf_log.size(), 0);

    // simultaneous press under back-pressure
    rst_on(4'h0);
    rst_off();
    bus.evt_ready = 1'b0;
    btn_in = 4'hC;
    step(20);
    chk("bp_valid", int'(bus.evt_valid), 1);
    chk("bp_id", int'(bus.evt_id), 2);
    chk("bp_type", int'(bus.evt_type), int'(EVT_PRESS));
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if ({bus.evt_valid, bus.evt_id, bus.evt_type} !== 5'b1_10_00)
        bad++;
    end
    chk("bp_hold_stable", bad, 0);
    bus.evt_ready = 1'b1;
    step(4);
    chk_ev("bp_first", 0, 2, int'(EVT_PRESS));
    chk_ev("bp_second", 1, 3, int'(EVT_PRESS));
    if (ev_cyc.size() >= 2)
      chk("bp_back_to_back", ev_cyc[1] - ev_cyc[0], 1);
    else
      chk("bp_back_to_back_missing", ev_cyc.size(), 2);
    btn_in = 4'h0;

    // long hold then release
    rst_on(4'h0);
    rst_off();
    btn_in = 4'h1;
    step(52);
    btn_in = 4'h0;
    step(20);
    exp_id.delete();
    exp_ty.delete();
    add_exp(0, EVT_PRESS);
`ifdef BTN_LONG_PRESS_EN
    add_exp(0, EVT_LONG);
`endif
    add_exp(0, EVT_RELEASE);
    chk_list("long");

    // pending overflow while the port is stalled
    rst_on(4'h0);
    rst_off();
    bus.evt_ready = 1'b0;
    btn_in = 4'h1;
    wait_state(4'h1, 20, "ovf_btn0");
    step(2);
    btn_in = 4'h3;
    wait_state(4'h3, 20, "ovf_press1");
    step(1);
    btn_in = 4'h1;
    wait_state(4'h1, 20, "ovf_release1");
    step(1);
    chk("ovf_none_yet", ovf_log.size(), 0);
    btn_in = 4'h3;
    wait_state(4'h3, 20, "ovf_press2");
    step(3);
    chk("ovf_pulses", ovf_log.size(), 1);
    chk("ovf_stalled_events", ev_id.size(), 0);
    bus.evt_ready = 1'b1;
    step(8);
    exp_id.delete();
    exp_ty.delete();
    add_exp(0, EVT_PRESS);
    add_exp(1, EVT_PRESS);
`ifdef BTN_LONG_PRESS_EN
    add_exp(0, EVT_LONG);
`endif
    add_exp(1, EVT_RELEASE);
    chk_list("ovf_drain");
    chk("ovf_final_pulses", ovf_log.size(), 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
